// File: rtl/tpu_tile_ctrl.sv
// rtl/tpu_tile_ctrl.sv - tile sequencer for the 4x4 systolic array
// Streams A/B operands in 4-deep K chunks, runs the array per chunk and writes accumulated C tiles.
module tpu_tile_ctrl #(
    parameter int ADDR_BITS  = 16,
    parameter int DATA_BITS  = 32,
    parameter int DATAC_BITS = 128,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            m_tiles,
    input  logic [7:0]            n_tiles,
    input  logic [ADDR_BITS-1:0]  k_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_BITS-1:0]  A_index,
    output logic [ADDR_BITS-1:0]  B_index,
    input  logic [DATA_BITS-1:0]  A_data_in,
    input  logic [DATA_BITS-1:0]  B_data_in,
    output logic [ADDR_BITS-1:0]  C_index,
    output logic                  C_wr_en,
    output logic [DATAC_BITS-1:0] C_data_out,
    output logic                  sa_rst_n,
    output logic [DATA_BITS-1:0]  local_buffer_A0,
    output logic [DATA_BITS-1:0]  local_buffer_A1,
    output logic [DATA_BITS-1:0]  local_buffer_A2,
    output logic [DATA_BITS-1:0]  local_buffer_A3,
    output logic [DATA_BITS-1:0]  local_buffer_B0,
    output logic [DATA_BITS-1:0]  local_buffer_B1,
    output logic [DATA_BITS-1:0]  local_buffer_B2,
    output logic [DATA_BITS-1:0]  local_buffer_B3,
    input  logic                  sa_done,
    input  logic [DATAC_BITS-1:0] sa_C0,
    input  logic [DATAC_BITS-1:0] sa_C1,
    input  logic [DATAC_BITS-1:0] sa_C2,
    input  logic [DATAC_BITS-1:0] sa_C3
);
    localparam int CW_RAW = $clog2(TIMEOUT + 1);
    localparam int CW     = (CW_RAW < 3) ? 3 : CW_RAW;
    localparam logic [ADDR_BITS:0] CHUNK = (ADDR_BITS + 1)'(4);

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_FETCH, S_SARST, S_RUN, S_ACC, S_WRITE, S_FIN
    } state_t;

    state_t                state, state_nx;
    logic [CW-1:0]         cyc;
    logic [7:0]            m_tiles_q, n_tiles_q, m_cnt, n_cnt;
    logic [ADDR_BITS-1:0]  k_len_q, k0, a_base, b_base, c_base;
    logic                  armed;
    logic [31:0]           acc [4][4];
    logic [DATA_BITS-1:0]  lb_a [4];
    logic [DATA_BITS-1:0]  lb_b [4];
    logic [DATAC_BITS-1:0] sa_c [4];
    logic                  more_chunks, last_n, last_m, slot_valid;
    logic [1:0]            slot;
    logic [1:0]            row;

    assign sa_c[0] = sa_C0;
    assign sa_c[1] = sa_C1;
    assign sa_c[2] = sa_C2;
    assign sa_c[3] = sa_C3;

    assign local_buffer_A0 = lb_a[0];
    assign local_buffer_A1 = lb_a[1];
    assign local_buffer_A2 = lb_a[2];
    assign local_buffer_A3 = lb_a[3];
    assign local_buffer_B0 = lb_b[0];
    assign local_buffer_B1 = lb_b[1];
    assign local_buffer_B2 = lb_b[2];
    assign local_buffer_B3 = lb_b[3];

    // Comparisons use one extra bit so k0+4 cannot wrap near the top of the index space.
    assign more_chunks = ({1'b0, k0} + CHUNK) < {1'b0, k_len_q};
    assign slot        = 2'(cyc - CW'(1));
    assign slot_valid  = ({1'b0, k0} + {{(ADDR_BITS-1){1'b0}}, slot}) < {1'b0, k_len_q};
    assign last_n      = (n_cnt + 8'd1) == n_tiles_q;
    assign last_m      = (m_cnt + 8'd1) == m_tiles_q;
    assign row         = cyc[1:0];

    always_comb begin
        state_nx   = state;
        busy       = (state != S_IDLE);
        done       = (state == S_FIN);
        C_wr_en    = 1'b0;
        A_index    = '0;
        B_index    = '0;
        C_index    = '0;
        C_data_out = '0;
        // armed keeps the array out of reset between runs so its results survive into ACC
        sa_rst_n   = (state == S_RUN) || (armed && state != S_SARST);
        case (state)
            S_IDLE: begin
                if (start) state_nx = (m_tiles == 8'd0 || n_tiles == 8'd0) ? S_FIN : S_CLR;
            end
            S_CLR: state_nx = (k_len_q == '0) ? S_WRITE : S_FETCH;
            S_FETCH: begin
                A_index = a_base + k0 + ADDR_BITS'(cyc);
                B_index = b_base + k0 + ADDR_BITS'(cyc);
                if (cyc == CW'(4)) state_nx = S_SARST;
            end
            S_SARST: if (cyc == CW'(1)) state_nx = S_RUN;
            S_RUN: begin
                if (sa_done)                        state_nx = S_ACC;
                else if (cyc == CW'(TIMEOUT - 1))   state_nx = S_FIN;
            end
            S_ACC: state_nx = more_chunks ? S_FETCH : S_WRITE;
            S_WRITE: begin
                C_wr_en    = 1'b1;
                C_index    = c_base + ADDR_BITS'(row);
                C_data_out = DATAC_BITS'({acc[row][0], acc[row][1], acc[row][2], acc[row][3]});
                if (cyc == CW'(3)) state_nx = (last_n && last_m) ? S_FIN : S_CLR;
            end
            S_FIN: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cyc       <= '0;
            m_tiles_q <= '0;
            n_tiles_q <= '0;
            m_cnt     <= '0;
            n_cnt     <= '0;
            k_len_q   <= '0;
            k0        <= '0;
            a_base    <= '0;
            b_base    <= '0;
            c_base    <= '0;
            armed     <= 1'b0;
            err       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                lb_a[i] <= '0;
                lb_b[i] <= '0;
                for (int j = 0; j < 4; j++) acc[i][j] <= '0;
            end
        end else begin
            state <= state_nx;
            cyc   <= (state_nx != state) ? '0 : cyc + CW'(1);

            if (state == S_RUN)
                armed <= 1'b1;
            else if (state == S_SARST || state == S_IDLE || state == S_FIN)
                armed <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        m_tiles_q <= m_tiles;
                        n_tiles_q <= n_tiles;
                        k_len_q   <= k_len;
                        m_cnt     <= '0;
                        n_cnt     <= '0;
                        a_base    <= '0;
                        b_base    <= '0;
                        c_base    <= '0;
                        err       <= 1'b0;
                    end
                end
                S_CLR: begin
                    k0 <= '0;
                    for (int i = 0; i < 4; i++)
                        for (int j = 0; j < 4; j++) acc[i][j] <= '0;
                end
                S_FETCH: begin
                    // read data lags its index by one cycle, so slot cyc-1 lands now
                    if (cyc != '0) begin
                        lb_a[slot] <= slot_valid ? A_data_in : '0;
                        lb_b[slot] <= slot_valid ? B_data_in : '0;
                    end
                end
                S_RUN: begin
                    if (!sa_done && cyc == CW'(TIMEOUT - 1)) err <= 1'b1;
                end
                S_ACC: begin
                    for (int i = 0; i < 4; i++)
                        for (int j = 0; j < 4; j++)
                            acc[i][j] <= acc[i][j] + sa_c[i][DATAC_BITS-1-32*j -: 32];
                    if (more_chunks) k0 <= k0 + ADDR_BITS'(4);
                end
                S_WRITE: begin
                    if (cyc == CW'(3)) begin
                        c_base <= c_base + ADDR_BITS'(4);
                        if (last_n) begin
                            n_cnt  <= '0;
                            b_base <= '0;
                            m_cnt  <= m_cnt + 8'd1;
                            a_base <= a_base + k_len_q;
                        end else begin
                            n_cnt  <= n_cnt + 8'd1;
                            b_base <= b_base + k_len_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
